// File: rtl/voice_allocator_if.sv
// Key-event handshake between the PS/2 key decoder (master) and the voice allocator (slave).
interface voice_allocator_if #(
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 3
);
  logic              key_valid;
  logic              key_ready;
  logic              key_on;
  logic [NOTE_W-1:0] key_note;
  logic [OCT_W-1:0]  key_octave;

  modport master (
    output key_valid, key_on, key_note, key_octave,
    input  key_ready
  );

  modport slave (
    input  key_valid, key_on, key_note, key_octave,
    output key_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps key press/release events onto NUM_VOICES voice slots.
// Define VOICE_STEAL_EN to steal the oldest busy voice on a press when no voice is free.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 4,
  parameter int OCT_W      = 3,
  localparam int VIDX_W    = $clog2(NUM_VOICES),
  localparam int AGE_W     = VIDX_W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  voice_allocator_if.slave             key_if,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*OCT_W-1:0]  voice_octave,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic                         done,
  output logic [VIDX_W-1:0]            done_voice,
  output logic                         steal,
  output logic                         drop,
  output logic [VIDX_W:0]              active_count
);

  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;

  state_t state_q, state_n;

  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [OCT_W-1:0]  ev_oct_q;

  logic [NUM_VOICES-1:0] gate_q, gate_n;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_n [NUM_VOICES];
  logic [OCT_W-1:0]      oct_q  [NUM_VOICES];
  logic [OCT_W-1:0]      oct_n  [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_n  [NUM_VOICES];

  logic              hit_c, hit_q, free_any_c, free_any_q;
  logic [VIDX_W-1:0] match_c, match_q, free_c, free_q;

  logic [NUM_VOICES-1:0] trig_n, trig_q;
  logic                  done_n, steal_n, drop_n;
  logic [VIDX_W-1:0]     dvoice_n;
  logic [VIDX_W:0]       count_n;
  logic [VIDX_W-1:0]     tgt;
  logic                  press_ok;
  logic                  accept;

  assign key_if.key_ready = (state_q == IDLE) && !all_off;
  assign accept           = key_if.key_valid && key_if.key_ready;

  // Lowest-index match and lowest-index free slot
  always_comb begin
    hit_c      = 1'b0;
    match_c    = '0;
    free_any_c = 1'b0;
    free_c     = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!hit_c && gate_q[i] && note_q[i] == ev_note_q && oct_q[i] == ev_oct_q) begin
        hit_c   = 1'b1;
        match_c = VIDX_W'(i);
      end
      if (!free_any_c && !gate_q[i]) begin
        free_any_c = 1'b1;
        free_c     = VIDX_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0] oldest_c, oldest_q;
  logic [AGE_W-1:0]  oldest_age;

  // Strict compare keeps the lowest index on equal ages
  always_comb begin
    oldest_c   = '0;
    oldest_age = age_q[0];
    for (int unsigned i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > oldest_age) begin
        oldest_age = age_q[i];
        oldest_c   = VIDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  oldest_q <= '0;
    else if (state_q == LOOKUP) oldest_q <= oldest_c;
  end
`endif

  always_comb begin
    state_n  = state_q;
    gate_n   = gate_q;
    note_n   = note_q;
    oct_n    = oct_q;
    age_n    = age_q;
    trig_n   = '0;
    done_n   = 1'b0;
    steal_n  = 1'b0;
    drop_n   = 1'b0;
    dvoice_n = '0;
    tgt      = '0;
    press_ok = 1'b0;
    if (all_off) begin
      state_n = IDLE;
      gate_n  = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) age_n[i] = '0;
    end else begin
      case (state_q)
        IDLE:   if (key_if.key_valid) state_n = LOOKUP;
        LOOKUP: state_n = COMMIT;
        COMMIT: begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (ev_on_q) begin
            press_ok = 1'b1;
            if (hit_q)           tgt = match_q;
            else if (free_any_q) tgt = free_q;
            else begin
`ifdef VOICE_STEAL_EN
              tgt     = oldest_q;
              steal_n = 1'b1;
`else
              press_ok = 1'b0;
              drop_n   = 1'b1;
`endif
            end
            if (press_ok) begin
              dvoice_n = tgt;
              for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (VIDX_W'(i) == tgt) begin
                  gate_n[i] = 1'b1;
                  note_n[i] = ev_note_q;
                  oct_n[i]  = ev_oct_q;
                  age_n[i]  = '0;
                  trig_n[i] = 1'b1;
                end else if (gate_q[i] && age_q[i] != '1) begin
                  age_n[i] = age_q[i] + 1'b1;
                end
              end
            end
          end else if (hit_q) begin
            dvoice_n = match_q;
            for (int unsigned i = 0; i < NUM_VOICES; i++)
              if (VIDX_W'(i) == match_q) gate_n[i] = 1'b0;
          end else begin
            drop_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    count_n = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      count_n = count_n + (VIDX_W+1)'(gate_n[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      ev_oct_q     <= '0;
      gate_q       <= '0;
      hit_q        <= 1'b0;
      match_q      <= '0;
      free_any_q   <= 1'b0;
      free_q       <= '0;
      trig_q       <= '0;
      done         <= 1'b0;
      steal        <= 1'b0;
      drop         <= 1'b0;
      done_voice   <= '0;
      active_count <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        oct_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_n;
      gate_q       <= gate_n;
      note_q       <= note_n;
      oct_q        <= oct_n;
      age_q        <= age_n;
      trig_q       <= trig_n;
      done         <= done_n;
      steal        <= steal_n;
      drop         <= drop_n;
      done_voice   <= dvoice_n;
      active_count <= count_n;
      if (accept) begin
        ev_on_q   <= key_if.key_on;
        ev_note_q <= key_if.key_note;
        ev_oct_q  <= key_if.key_octave;
      end
      if (state_q == LOOKUP) begin
        hit_q      <= hit_c;
        match_q    <= match_c;
        free_any_q <= free_any_c;
        free_q     <= free_c;
      end
    end
  end

  always_comb begin
    voice_gate = gate_q;
    voice_trig = trig_q;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
      voice_octave[i*OCT_W +: OCT_W] = oct_q[i];
    end
  end

endmodule
